// File: rtl/intr_ack_master.sv
// intr_ack_master: CPU-side INTA acknowledge sequencer and OCW2 end-of-interrupt writer for the PIC.
//   clk, reset (async, active-high)
//   INT (async, synchronized), int_enable, auto_eoi, eoi_req/eoi_specific/eoi_level, data_in[7:0]
//   INTA, WR (active-low strobes), A0, data_out[7:0], data_oe, vector[7:0], vector_valid, eoi_done, busy
module intr_ack_master #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2,
  parameter int WR_LOW_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic       int_enable,
  input  logic       auto_eoi,
  input  logic       eoi_req,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic [7:0] data_in,
  output logic       INTA,
  output logic       WR,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       eoi_done,
  output logic       busy
);
  localparam int MAXC = (INTA_LOW_CYCLES > INTA_GAP_CYCLES ? INTA_LOW_CYCLES : INTA_GAP_CYCLES) > WR_LOW_CYCLES
                      ? (INTA_LOW_CYCLES > INTA_GAP_CYCLES ? INTA_LOW_CYCLES : INTA_GAP_CYCLES) : WR_LOW_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LOW_LAST = CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(INTA_GAP_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_LOW_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ACK1, GAP, ACK2, EOI_WR, EOI_HOLD} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    sync_q;
  logic          armed_q;
  logic          pend_q;
  logic          pend_spec_q;
  logic [2:0]    pend_lvl_q;
  logic          int_s;
  logic          start_ack;
  assign int_s = sync_q[1];
  // A pending EOI always wins over a new acknowledge in IDLE
  assign start_ack = state_q == IDLE && !pend_q && int_s && armed_q && int_enable;
  assign busy = state_q != IDLE;
  assign A0 = 1'b0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sync_q       <= '0;
      armed_q      <= 1'b1;
      pend_q       <= 1'b0;
      pend_spec_q  <= 1'b0;
      pend_lvl_q   <= '0;
      INTA         <= 1'b1;
      WR           <= 1'b1;
      data_out     <= '0;
      data_oe      <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
      eoi_done     <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], INT};
      vector_valid <= 1'b0;
      eoi_done     <= 1'b0;
      // Re-arm only after INT has been seen low, so a held INT cannot retrigger
      armed_q      <= !int_s || (armed_q && !start_ack);
      // First request wins; later ones are dropped until the write finishes
      if (eoi_req && !auto_eoi && !pend_q) begin
        pend_q      <= 1'b1;
        pend_spec_q <= eoi_specific;
        pend_lvl_q  <= eoi_level;
      end
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pend_q) begin
            state_q  <= EOI_WR;
            WR       <= 1'b0;
            data_oe  <= 1'b1;
            data_out <= pend_spec_q ? {5'b01100, pend_lvl_q} : 8'h20;
          end else if (start_ack) begin
            state_q <= ACK1;
            INTA    <= 1'b0;
          end
        end
        ACK1: if (cnt_q == LOW_LAST) begin
          state_q <= GAP;
          cnt_q   <= '0;
          INTA    <= 1'b1;
        end
        GAP: if (cnt_q == GAP_LAST) begin
          state_q <= ACK2;
          cnt_q   <= '0;
          INTA    <= 1'b0;
        end
        ACK2: if (cnt_q == LOW_LAST) begin
          state_q      <= IDLE;
          cnt_q        <= '0;
          INTA         <= 1'b1;
          vector       <= data_in;
          vector_valid <= 1'b1;
        end
        EOI_WR: if (cnt_q == WR_LAST) begin
          state_q <= EOI_HOLD;
          cnt_q   <= '0;
          WR      <= 1'b1;
        end
        EOI_HOLD: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          data_oe  <= 1'b0;
          eoi_done <= 1'b1;
          pend_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intr_ack_master.sv
// tb_intr_ack_master: scoreboard bench for the INTA acknowledge and OCW2 EOI sequencer.
module tb_intr_ack_master;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       INT = 1'b0;
  logic       int_enable = 1'b0;
  logic       auto_eoi = 1'b0;
  logic       eoi_req = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic       INTA, WR, A0, data_oe, vector_valid, eoi_done, busy;
  logic [7:0] data_out, vector;
  int checks = 0;
  int passes = 0;
  int vv_cnt = 0;
  int wr_falls = 0;
  logic wr_prev = 1'b1;
  logic [7:0] vq[$];
  logic [7:0] eq[$];
  intr_ack_master dut (
    .clk(clk), .reset(reset), .INT(INT), .int_enable(int_enable), .auto_eoi(auto_eoi),
    .eoi_req(eoi_req), .eoi_specific(eoi_specific), .eoi_level(eoi_level), .data_in(data_in),
    .INTA(INTA), .WR(WR), .A0(A0), .data_out(data_out), .data_oe(data_oe), .vector(vector),
    .vector_valid(vector_valid), .eoi_done(eoi_done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (vector_valid) vv_cnt <= vv_cnt + 1;
    if (wr_prev && !WR) wr_falls <= wr_falls + 1;
    wr_prev <= WR;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_vv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (vector_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic settle_low;
    INT = 1'b0;
    repeat (4) tick();
  endtask
  task automatic test_reset;
    repeat (3) tick();
    checks++;
    if ({INTA, WR, A0, data_oe, vector_valid, eoi_done, busy, data_out, vector} !== {7'b1100000, 8'h00, 8'h00})
      $display("FAIL reset_state got %b required %b", {INTA, WR, A0, data_oe, vector_valid, eoi_done, busy, data_out, vector}, {7'b1100000, 16'h0});
    else passes++;
    reset = 1'b0;
    repeat (3) tick();
  endtask
  task automatic test_ack;
    logic [7:0] e;
    int_enable = 1'b1;
    data_in = 8'h48;
    INT = 1'b1;
    vq.push_back(8'h48);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (INTA !== !(k == 3 || k == 4 || k == 7 || k == 8) || busy !== (k >= 3 && k <= 8) || vector_valid !== (k == 9))
        $display("FAIL ack_timing k=%0d got INTA=%b busy=%b vv=%b", k, INTA, busy, vector_valid);
      else passes++;
      if (k == 9) begin
        checks++;
        if (vq.size() == 0) $display("FAIL ack_vector got empty scoreboard required entry");
        else begin
          e = vq.pop_front();
          if (vector !== e) $display("FAIL ack_vector got %h required %h", vector, e);
          else passes++;
        end
      end
    end
    settle_low();
  endtask
  task automatic test_eoi_nonspec;
    logic [7:0] e;
    int w0;
    w0 = wr_falls;
    eoi_req = 1'b1;
    eoi_specific = 1'b0;
    eq.push_back(8'h20);
    for (int k = 1; k <= 6; k++) begin
      tick();
      eoi_req = 1'b0;
      checks++;
      if (WR !== !(k == 2 || k == 3) || data_oe !== (k >= 2 && k <= 4) || eoi_done !== (k == 5) || A0 !== 1'b0)
        $display("FAIL eoi_timing k=%0d got WR=%b oe=%b done=%b A0=%b", k, WR, data_oe, eoi_done, A0);
      else passes++;
      if (k == 2) begin
        checks++;
        if (eq.size() == 0) $display("FAIL eoi_data got empty scoreboard required entry");
        else begin
          e = eq.pop_front();
          if (data_out !== e) $display("FAIL eoi_data got %h required %h", data_out, e);
          else passes++;
        end
      end
    end
    #0;
    checks++;
    if (wr_falls - w0 !== 1) $display("FAIL eoi_pulses got %0d required 1", wr_falls - w0);
    else passes++;
  endtask
  task automatic test_eoi_spec;
    logic [7:0] e;
    int w0;
    w0 = wr_falls;
    eoi_req = 1'b1;
    eoi_specific = 1'b1;
    eoi_level = 3'd5;
    eq.push_back(8'h65);
    for (int k = 1; k <= 8; k++) begin
      tick();
      eoi_req = (k == 2);
      eoi_level = 3'd2;
      if (k == 2) begin
        checks++;
        if (eq.size() == 0) $display("FAIL eoi_spec_data got empty scoreboard required entry");
        else begin
          e = eq.pop_front();
          if (data_out !== e || WR !== 1'b0) $display("FAIL eoi_spec_data got %h WR=%b required %h WR=0", data_out, WR, e);
          else passes++;
        end
      end
    end
    checks++;
    if (wr_falls - w0 !== 1) $display("FAIL eoi_drop got %0d pulses required 1", wr_falls - w0);
    else passes++;
    auto_eoi = 1'b1;
    eoi_req = 1'b1;
    w0 = wr_falls;
    for (int k = 1; k <= 6; k++) begin
      tick();
      eoi_req = 1'b0;
      checks++;
      if (busy !== 1'b0 || WR !== 1'b1) $display("FAIL aeoi_idle k=%0d got busy=%b WR=%b required 0/1", k, busy, WR);
      else passes++;
    end
    checks++;
    if (wr_falls !== w0) $display("FAIL aeoi_pulses got %0d required 0", wr_falls - w0);
    else passes++;
    auto_eoi = 1'b0;
    eoi_specific = 1'b0;
  endtask
  task automatic test_eoi_during_ack;
    logic [7:0] e;
    data_in = 8'hA3;
    INT = 1'b1;
    vq.push_back(8'hA3);
    eq.push_back(8'h20);
    for (int k = 1; k <= 11; k++) begin
      tick();
      eoi_req = (k == 3);
      if (k == 9) begin
        checks++;
        if (vq.size() == 0) $display("FAIL eda_vector got empty scoreboard required entry");
        else begin
          e = vq.pop_front();
          if (vector_valid !== 1'b1 || vector !== e || WR !== 1'b1)
            $display("FAIL eda_vector got vv=%b vec=%h WR=%b required 1/%h/1", vector_valid, vector, WR, e);
          else passes++;
        end
      end
      if (k == 10) begin
        checks++;
        if (eq.size() == 0) $display("FAIL eda_write got empty scoreboard required entry");
        else begin
          e = eq.pop_front();
          if (WR !== 1'b0 || data_out !== e) $display("FAIL eda_write got WR=%b data=%h required 0/%h", WR, data_out, e);
          else passes++;
        end
      end
    end
    repeat (3) tick();
    settle_low();
  endtask
  task automatic test_simul;
    logic [7:0] e;
    data_in = 8'h5C;
    INT = 1'b1;
    vq.push_back(8'h5C);
    for (int k = 1; k <= 13; k++) begin
      tick();
      eoi_req = (k == 1);
      if (k == 3) begin
        checks++;
        if (WR !== 1'b0 || INTA !== 1'b1) $display("FAIL simul_eoi_first got WR=%b INTA=%b required 0/1", WR, INTA);
        else passes++;
      end
      if (k == 6) begin
        checks++;
        if (eoi_done !== 1'b1) $display("FAIL simul_done got %b required 1", eoi_done);
        else passes++;
      end
      if (k == 7) begin
        checks++;
        if (INTA !== 1'b0) $display("FAIL simul_ack got INTA=%b required 0", INTA);
        else passes++;
      end
      if (k == 13) begin
        checks++;
        if (vq.size() == 0) $display("FAIL simul_vector got empty scoreboard required entry");
        else begin
          e = vq.pop_front();
          if (vector_valid !== 1'b1 || vector !== e) $display("FAIL simul_vector got vv=%b vec=%h required 1/%h", vector_valid, vector, e);
          else passes++;
        end
      end
    end
    settle_low();
  endtask
  task automatic test_int_enable;
    logic [7:0] e;
    bit ok;
    int_enable = 1'b0;
    data_in = 8'h91;
    INT = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (INTA !== 1'b1 || busy !== 1'b0) $display("FAIL inten_blocked k=%0d got INTA=%b busy=%b", k, INTA, busy);
      else passes++;
    end
    int_enable = 1'b1;
    vq.push_back(8'h91);
    tick();
    checks++;
    if (INTA !== 1'b0) $display("FAIL inten_start got INTA=%b required 0", INTA);
    else passes++;
    wait_vv(ok);
    checks++;
    if (!ok) $display("FAIL inten_vector got timeout required vector_valid");
    else if (vq.size() == 0) $display("FAIL inten_vector got empty scoreboard required entry");
    else begin
      e = vq.pop_front();
      if (vector !== e) $display("FAIL inten_vector got %h required %h", vector, e);
      else passes++;
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (INTA !== 1'b1 || busy !== 1'b0) $display("FAIL held_no_restart k=%0d got INTA=%b busy=%b", k, INTA, busy);
      else passes++;
    end
    settle_low();
    data_in = 8'h17;
    INT = 1'b1;
    vq.push_back(8'h17);
    repeat (3) tick();
    checks++;
    if (INTA !== 1'b0) $display("FAIL rearm_start got INTA=%b required 0", INTA);
    else passes++;
    wait_vv(ok);
    checks++;
    if (!ok) $display("FAIL rearm_vector got timeout required vector_valid");
    else if (vq.size() == 0) $display("FAIL rearm_vector got empty scoreboard required entry");
    else begin
      e = vq.pop_front();
      if (vector !== e) $display("FAIL rearm_vector got %h required %h", vector, e);
      else passes++;
    end
    settle_low();
  endtask
  task automatic test_reset_mid;
    logic [7:0] e;
    bit ok;
    int v0;
    data_in = 8'hEE;
    INT = 1'b1;
    repeat (7) tick();
    checks++;
    if (INTA !== 1'b0) $display("FAIL rmid_in_ack2 got INTA=%b required 0", INTA);
    else passes++;
    v0 = vv_cnt;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (INTA !== 1'b1 || vector !== 8'h00 || busy !== 1'b0 || WR !== 1'b1)
      $display("FAIL rmid_async got INTA=%b vec=%h busy=%b WR=%b required 1/00/0/1", INTA, vector, busy, WR);
    else passes++;
    repeat (3) tick();
    checks++;
    if (vv_cnt !== v0 || eoi_done !== 1'b0) $display("FAIL rmid_no_pulse got vv=%0d done=%b required 0/0", vv_cnt - v0, eoi_done);
    else passes++;
    reset = 1'b0;
    vq.push_back(8'hEE);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (INTA !== (k != 3)) $display("FAIL rmid_restart k=%0d got INTA=%b required %b", k, INTA, k != 3);
      else passes++;
    end
    wait_vv(ok);
    checks++;
    if (!ok) $display("FAIL rmid_vector got timeout required vector_valid");
    else if (vq.size() == 0) $display("FAIL rmid_vector got empty scoreboard required entry");
    else begin
      e = vq.pop_front();
      if (vector !== e) $display("FAIL rmid_vector got %h required %h", vector, e);
      else passes++;
    end
    settle_low();
  endtask
  initial begin
    test_reset();
    test_ack();
    test_eoi_nonspec();
    test_eoi_spec();
    test_eoi_during_ack();
    test_simul();
    test_int_enable();
    test_reset_mid();
    checks++;
    if (vq.size() != 0 || eq.size() != 0) $display("FAIL scoreboard_drain got %0d/%0d left required 0/0", vq.size(), eq.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/intr_ack_master.md
# intr_ack_master

CPU-side interrupt acknowledge and EOI sequencer for the programmable interrupt controller. It watches the controller's INT line and runs the two-pulse INTA acknowledge cycle. It captures the 8-bit vector driven on the second pulse and hands it to the core. It also issues OCW2 end-of-interrupt write cycles (non-specific or specific) on request. It sits between the processor model and the controller's INTA/data/WR pins and is the initiator the controller's in-service logic responds to.

## Interface
- INTA_LOW_CYCLES, 2, clk cycles each INTA pulse is held low (≥1)
- INTA_GAP_CYCLES, 2, clk cycles INTA is high between the two pulses (≥1)
- WR_LOW_CYCLES, 2, clk cycles WR is held low during an OCW2 write (≥1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- INT  in  1  interrupt request from controller, asynchronous, 2-flop synchronized
- int_enable  in  1  core interrupt-enable flag; new acknowledge starts only when 1
- auto_eoi  in  1  1 = controller in AEOI mode; eoi_req ignored
- eoi_req  in  1  one-cycle EOI request from core
- eoi_specific  in  1  sampled with eoi_req; 1 = specific EOI
- eoi_level  in  3  sampled with eoi_req; IR level for specific EOI
- data_in  in  8  controller data bus (vector)
- INTA  out  1  acknowledge strobe, active-low, idle 1
- WR  out  1  write strobe, active-low, idle 1
- A0  out  1  address bit, 0 during OCW2 write, else 0
- data_out  out  8  OCW2 byte
- data_oe  out  1  1 while data_out drives the bus
- vector  out  8  last captured vector
- vector_valid  out  1  one-cycle pulse when vector updates
- eoi_done  out  1  one-cycle pulse when OCW2 write completes
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- States: IDLE, ACK1, GAP, ACK2, EOI_WR, EOI_HOLD.
- int_s = second synchronizer flop. armed flag: reset 1, cleared on leaving IDLE to ACK1, set whenever int_s = 0.
- Pending-EOI latch: captured on eoi_req when auto_eoi = 0 (stores specific flag and level). Accepted in any state. A request while already pending is dropped; the first request is kept.
- IDLE priority: pending EOI → EOI_WR; else int_s & armed & int_enable → ACK1; else stay.
- ACK1: INTA = 0 for INTA_LOW_CYCLES, then GAP.
- GAP: INTA = 1 for INTA_GAP_CYCLES, then ACK2.
- ACK2: INTA = 0 for INTA_LOW_CYCLES. On the last low cycle, vector <= data_in. Next state IDLE, where INTA = 1 and vector_valid = 1 for one cycle.
- Once ACK1 is entered, the sequence always completes, whatever INT or int_enable do.
- EOI_WR: data_oe = 1, A0 = 0, WR = 0 for WR_LOW_CYCLES. data_out = 8'h20 for non-specific, or 8'h60 | {5'b0, level} for specific. Then EOI_HOLD.
- EOI_HOLD: WR = 1, data_oe still 1 with data held, for one cycle. Then IDLE with eoi_done = 1 and the pending latch cleared.
- Counters are sized to the largest parameter and cleared on every state entry.

## Timing
- Reset values (asynchronous): INTA = 1, WR = 1, A0 = 0, data_out = 0, data_oe = 0, vector = 8'h00, vector_valid = 0, eoi_done = 0, busy = 0, state = IDLE, armed = 1, pending cleared, synchronizers 0.
- Reset asserted mid-sequence forces the strobes high immediately. There is no partial vector update and no eoi_done.
- INT rising before edge 0: int_s = 1 after edge 2. ACK1 is entered at edge 3, so INTA falls after edge 3.
- With defaults: INTA low for cycles 3–4, high for 5–6, low for 7–8. Vector is captured at edge 9. vector_valid and INTA are high during cycle 9.
- Full acknowledge = 2·INTA_LOW_CYCLES + INTA_GAP_CYCLES clk cycles from ACK1 entry to IDLE.
- EOI write = WR_LOW_CYCLES + 1 cycles. eoi_done is asserted in the first IDLE cycle after that.
- Back-to-back: from IDLE, next state is decided in the same cycle that vector_valid or eoi_done is high.
- INT held high continuously after an acknowledge does not restart; armed requires int_s = 0 first.

## Test plan
- INT rise, int_enable = 1, data_in = 8'h48 during ACK2 -> two INTA low pulses of 2 cycles with a 2-cycle gap; vector = 8'h48 with vector_valid at cycle 9; busy high cycles 3–8.
- eoi_req with eoi_specific = 0, auto_eoi = 0 -> WR low 2 cycles, data_out = 8'h20, A0 = 0, data_oe for 3 cycles, eoi_done one cycle later.
- eoi_req specific with level 5 -> data_out = 8'h65; second eoi_req during the write is dropped (exactly one WR pulse); auto_eoi = 1 with eoi_req -> no WR activity.
- eoi_req issued during ACK1 -> acknowledge completes first, then the EOI write starts the cycle vector_valid is high; simultaneous int_s and pending EOI in IDLE -> EOI first.
- int_enable = 0 with INT high -> INTA stays 1; raise int_enable -> sequence starts next cycle; INT held high after completion -> no second sequence until INT drops and rises.
- reset asserted during ACK2 -> INTA = 1 immediately, vector = 8'h00, no vector_valid; after release with INT high -> a fresh full sequence runs.
